// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter, PSR flags and branch/jump condition evaluation
module pc_branch_unit #(
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         instruction,
  input  logic                pcEn,
  input  logic                pcIncOrSet,
  input  logic                psrEn,
  input  logic [4:0]          aluFlags,
  input  logic [PC_WIDTH-1:0] targetReg,
  output logic [PC_WIDTH-1:0] pc,
  output logic [4:0]          psrFlags,
  output logic                taken,
  output logic [PC_WIDTH-1:0] linkAddr
);
  logic [3:0] op, cond;
  logic is_b, is_j, is_jal;
  logic n, z, f, l, c;
  logic [15:0] cond_vec;
  logic [PC_WIDTH-1:0] disp_ext, next_pc;
  assign op = instruction[15:12];
  assign cond = instruction[11:8];
  assign is_b = op == 4'b1100;
  assign is_j = op == 4'b0100 && instruction[7:4] == 4'b1100;
  assign is_jal = op == 4'b0100 && instruction[7:4] == 4'b1000;
  assign {n, z, f, l, c} = psrFlags;
  // One bit per condition code, indexed by cond; conditions see only the registered flags
  assign cond_vec = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~f, f,
                     ~n, n, ~l, l, ~c, c, ~z, z};
  assign taken = ((is_b | is_j) & cond_vec[cond]) | is_jal;
  assign linkAddr = pc + 1'b1;
  assign disp_ext = {{(PC_WIDTH-8){instruction[7]}}, instruction[7:0]};
  // Next PC: sequential unless a set request meets a taken branch/jump
  always_comb begin
    next_pc = (!pcIncOrSet || !taken) ? linkAddr : is_b ? pc + disp_ext : targetReg;
  end
  // PC and PSR registers; reset dominates both strobes
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc <= RESET_PC;
      psrFlags <= 5'b0;
    end else begin
      if (pcEn) pc <= next_pc;
      if (psrEn) psrFlags <= aluFlags;
    end
  end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed self-checking bench for pc_branch_unit
module tb_pc_branch_unit;
  logic clock = 1'b0;
  logic reset;
  logic [15:0] instruction;
  logic pcEn, pcIncOrSet, psrEn;
  logic [4:0] aluFlags;
  logic [15:0] targetReg;
  logic [15:0] pc;
  logic [4:0] psrFlags;
  logic taken;
  logic [15:0] linkAddr;
  int n_checks = 0;
  int n_fail = 0;

  pc_branch_unit dut (
    .clock(clock), .reset(reset), .instruction(instruction), .pcEn(pcEn),
    .pcIncOrSet(pcIncOrSet), .psrEn(psrEn), .aluFlags(aluFlags),
    .targetReg(targetReg), .pc(pc), .psrFlags(psrFlags), .taken(taken),
    .linkAddr(linkAddr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] v);
    instruction = 16'h4083;
    targetReg = v;
    pcEn = 1'b1;
    pcIncOrSet = 1'b1;
    psrEn = 1'b0;
    step();
    pcEn = 1'b0;
  endtask

  function automatic logic model_cond(input logic [3:0] cd, input logic [4:0] fl);
    logic nn, zz, ff, ll, cc;
    nn = fl[4]; zz = fl[3]; ff = fl[2]; ll = fl[1]; cc = fl[0];
    case (cd)
      4'd0: return zz;
      4'd1: return !zz;
      4'd2: return cc;
      4'd3: return !cc;
      4'd4: return ll;
      4'd5: return !ll;
      4'd6: return nn;
      4'd7: return !nn;
      4'd8: return ff;
      4'd9: return !ff;
      4'd10: return !ll && !zz;
      4'd11: return ll || zz;
      4'd12: return !nn && !zz;
      4'd13: return nn || zz;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    reset = 1'b0; pcEn = 1'b1; pcIncOrSet = 1'b1; psrEn = 1'b1;
    aluFlags = 5'h1F; instruction = 16'h4083; targetReg = 16'h1234;
    step();
    check("reset_pc", pc, 16'h0000);
    check("reset_psr", psrFlags, 5'h00);
    check("reset_link", linkAddr, 16'h0001);
    reset = 1'b1;

    set_pc(16'hFFFE);
    check("preload", pc, 16'hFFFE);
    pcEn = 1'b1; pcIncOrSet = 1'b0;
    step();
    check("inc_ffff", pc, 16'hFFFF);
    step();
    check("inc_wrap", pc, 16'h0000);
    pcEn = 1'b0;
    step();
    check("hold_inc", pc, 16'h0000);
    pcIncOrSet = 1'b1; instruction = 16'h4083; targetReg = 16'h1234;
    step();
    check("hold_jal", pc, 16'h0000);

    psrEn = 1'b1; aluFlags = 5'b01000;
    step();
    psrEn = 1'b0; aluFlags = 5'b10111;
    step();
    check("psr_hold", psrFlags, 5'b01000);
    set_pc(16'h0010);
    instruction = 16'hC0FC; pcIncOrSet = 1'b1;
    #1;
    check("beq_taken", taken, 1'b1);
    pcEn = 1'b1;
    step();
    check("beq_pc", pc, 16'h000C);
    set_pc(16'h0010);
    instruction = 16'hC1FC;
    #1;
    check("bne_taken", taken, 1'b0);
    pcEn = 1'b1;
    step();
    check("bne_pc", pc, 16'h0011);
    set_pc(16'h0002);
    instruction = 16'hCEFC; pcEn = 1'b1;
    step();
    check("disp_wrap", pc, 16'hFFFE);
    set_pc(16'h0005);
    instruction = 16'hCE7F; pcEn = 1'b1; pcIncOrSet = 1'b0;
    step();
    check("inc_ignores_branch", pc, 16'h0006);

    set_pc(16'h0020);
    targetReg = 16'h1234; instruction = 16'h4EC5;
    #1;
    check("juc_taken", taken, 1'b1);
    pcEn = 1'b1;
    step();
    check("juc_pc", pc, 16'h1234);
    set_pc(16'h0020);
    targetReg = 16'h1234; instruction = 16'h4FC5;
    #1;
    check("jnever_taken", taken, 1'b0);
    pcEn = 1'b1;
    step();
    check("jnever_pc", pc, 16'h0021);
    set_pc(16'h0020);
    targetReg = 16'h1234;
    #1;
    check("jal_taken", taken, 1'b1);
    check("jal_link", linkAddr, 16'h0021);
    pcEn = 1'b1;
    step();
    check("jal_pc", pc, 16'h1234);
    instruction = 16'h4003;
    #1;
    check("nonbranch_taken", taken, 1'b0);
    step();
    check("nonbranch_pc", pc, 16'h1235);
    instruction = 16'h0EC0;
    #1;
    check("op0_taken", taken, 1'b0);

    psrEn = 1'b1; aluFlags = 5'b00000; pcEn = 1'b0;
    step();
    set_pc(16'h0040);
    instruction = 16'hC002; psrEn = 1'b1; aluFlags = 5'b01000;
    pcEn = 1'b1; pcIncOrSet = 1'b1;
    #1;
    check("order_taken_old", taken, 1'b0);
    step();
    check("order_pc", pc, 16'h0041);
    check("order_psr", psrFlags, 5'b01000);
    psrEn = 1'b0;
    #1;
    check("order_taken_new", taken, 1'b1);
    step();
    check("order_pc2", pc, 16'h0043);

    pcEn = 1'b0;
    for (int cd = 0; cd < 16; cd++) begin
      for (int fl = 0; fl < 32; fl++) begin
        psrEn = 1'b1; aluFlags = 5'(fl);
        step();
        psrEn = 1'b0; aluFlags = ~5'(fl);
        instruction = {4'hC, 4'(cd), 8'h00};
        #1;
        check($sformatf("bcond_c%0d_f%0d", cd, fl), taken, model_cond(4'(cd), 5'(fl)));
        instruction = {4'h4, 4'(cd), 4'hC, 4'h0};
        #1;
        check($sformatf("jcond_c%0d_f%0d", cd, fl), taken, model_cond(4'(cd), 5'(fl)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
